expr_sig_collector: RTL and testbench

Downstream result compactor for the generated expression blocks. It accepts the 90-bit `y` result vector of an expression module, one vector per valid/ready handshake. Each accepted vector is folded to 32 bits and accumulated into a 32-bit MISR signature. After a programmed number of vectors, the block compares the signature against a golden value and reports pass/fail, so a regression run can check many expression outputs without storing each vector.

---
 rtl/expr_sig_collector.sv | 98 +++++++++
 tb/tb_expr_sig_collector.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/expr_sig_collector.sv
// Folds 90-bit expression results into a 32-bit MISR and checks it against a golden value.
// Latency: one cycle per accepted vector; done/pass one edge after the final accept.
// Backpressure: in_ready is high only while a run is active (registered state decode).
module expr_sig_collector #(
    parameter int          DATA_W = 90,
    parameter int          CNT_W  = 16,
    parameter logic [31:0] POLY   = 32'h04C11DB7,
    parameter logic [31:0] SEED   = 32'hFFFFFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [CNT_W-1:0]  num_vectors,
    input  logic [31:0]       golden,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [31:0]       signature,
    output logic [CNT_W-1:0]  count
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = '0;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t           state;
    logic [31:0]      sig;
    logic [31:0]      gold_q;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] target;
    logic             pass_q;

    logic [31:0] fold_val;
    logic [31:0] sig_next;
    logic        accept;

    // The fold assumes the 90-bit expression output width.
    assign fold_val = in_data[31:0] ^ in_data[63:32] ^ {6'b0, in_data[89:64]};
    assign sig_next = {sig[30:0], 1'b0} ^ (sig[31] ? POLY : 32'h0) ^ fold_val;
    assign accept   = in_valid && (state == S_RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= S_IDLE;
            sig    <= SEED;
            gold_q <= 32'h0;
            cnt    <= CNT_ZERO;
            target <= CNT_ZERO;
            pass_q <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        target <= num_vectors;
                        gold_q <= golden;
                        sig    <= SEED;
                        cnt    <= CNT_ZERO;
                        if (num_vectors == CNT_ZERO) begin
                            state  <= S_DONE;
                            pass_q <= (SEED == golden);
                        end else begin
                            state  <= S_RUN;
                            pass_q <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    // start is deliberately ignored here; only accepts advance the run.
                    if (accept) begin
                        sig <= sig_next;
                        cnt <= cnt + CNT_ONE;
                        if (cnt == target - CNT_ONE) begin
                            state  <= S_DONE;
                            pass_q <= (sig_next == gold_q);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state == S_RUN);
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);
    assign pass      = pass_q;
    assign signature = sig;
    assign count     = cnt;

endmodule

// File: tb/tb_expr_sig_collector.sv
// Directed bench for expr_sig_collector with a reference MISR and an expected-result queue.
module tb_expr_sig_collector;

    localparam int          DATA_W = 90;
    localparam int          CNT_W  = 16;
    localparam logic [31:0] POLY   = 32'h04C11DB7;
    localparam logic [31:0] SEED   = 32'hFFFFFFFF;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [CNT_W-1:0]  num_vectors = '0;
    logic [31:0]       golden = '0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              busy;
    logic              done;
    logic              pass;
    logic [31:0]       signature;
    logic [CNT_W-1:0]  count;

    typedef struct {
        logic [31:0]      sig;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    exp_t        sb_q[$];
    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_sig;
    logic [CNT_W-1:0] model_cnt;

    expr_sig_collector #(
        .DATA_W(DATA_W), .CNT_W(CNT_W), .POLY(POLY), .SEED(SEED)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .num_vectors(num_vectors),
        .golden(golden), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .count(count)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] misr(input logic [31:0] s, input logic [DATA_W-1:0] d);
        logic [31:0] f;
        f = d[31:0] ^ d[63:32] ^ {6'b0, d[89:64]};
        return {s[30:0], 1'b0} ^ (s[31] ? POLY : 32'h0) ^ f;
    endfunction

    function automatic logic [DATA_W-1:0] rnd_vec();
        return {$urandom_range(0, 32'h03FFFFFF), $urandom, $urandom};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [CNT_W-1:0] n, input logic [31:0] g);
        start       = 1'b1;
        num_vectors = n;
        golden      = g;
        model_sig   = SEED;
        model_cnt   = '0;
        step();
        start = 1'b0;
    endtask

    // Offer one vector; if the DUT is ready an expected result is queued and checked after the edge.
    task automatic offer(input logic v, input logic [DATA_W-1:0] d, input string tag);
        exp_t e;
        in_valid = v;
        in_data  = d;
        if (v && in_ready) begin
            model_sig = misr(model_sig, d);
            model_cnt = model_cnt + 1'b1;
            e.sig = model_sig;
            e.cnt = model_cnt;
            sb_q.push_back(e);
        end
        step();
        in_valid = 1'b0;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk({tag, "_sig"}, {32'h0, signature}, {32'h0, e.sig});
            chk({tag, "_cnt"}, {48'h0, count}, {48'h0, e.cnt});
        end else begin
            chk({tag, "_hold_sig"}, {32'h0, signature}, {32'h0, model_sig});
            chk({tag, "_hold_cnt"}, {48'h0, count}, {48'h0, model_cnt});
        end
    endtask

    initial begin
        logic [DATA_W-1:0] vecs[6];
        logic              pat[6];
        logic [31:0]       g;

        // Reset state
        #12;
        chk("rst_in_ready", {63'h0, in_ready}, 64'h0);
        chk("rst_busy", {63'h0, busy}, 64'h0);
        chk("rst_done", {63'h0, done}, 64'h0);
        chk("rst_pass", {63'h0, pass}, 64'h0);
        chk("rst_sig", {32'h0, signature}, {32'h0, SEED});
        chk("rst_cnt", {48'h0, count}, 64'h0);
        rst_n = 1'b1;
        step();

        // Zero-vector run
        do_start(16'd0, 32'hFFFFFFFF);
        chk("zero_done", {63'h0, done}, 64'h1);
        chk("zero_pass", {63'h0, pass}, 64'h1);
        chk("zero_sig", {32'h0, signature}, 64'hFFFFFFFF);
        chk("zero_busy", {63'h0, busy}, 64'h0);

        // Single zero vector, matching golden
        do_start(16'd1, 32'hFB3EE249);
        chk("one_busy", {63'h0, busy}, 64'h1);
        chk("one_ready", {63'h0, in_ready}, 64'h1);
        chk("one_done_lo", {63'h0, done}, 64'h0);
        offer(1'b1, '0, "one");
        chk("one_sig_const", {32'h0, signature}, 64'hFB3EE249);
        chk("one_done", {63'h0, done}, 64'h1);
        chk("one_pass", {63'h0, pass}, 64'h1);
        chk("one_ready_lo", {63'h0, in_ready}, 64'h0);

        // Same vector, wrong golden
        do_start(16'd1, 32'h0);
        offer(1'b1, '0, "one_bad");
        chk("one_bad_done", {63'h0, done}, 64'h1);
        chk("one_bad_pass", {63'h0, pass}, 64'h0);

        // Four vectors with valid toggling 1,0,1,1,0,1
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        g = SEED;
        for (int i = 0; i < 6; i++) begin
            vecs[i] = rnd_vec();
            if (pat[i]) g = misr(g, vecs[i]);
        end
        do_start(16'd4, g);
        for (int i = 0; i < 6; i++) begin
            chk("tog_done_lo", {63'h0, done}, 64'h0);
            offer(pat[i], vecs[i], "tog");
        end
        chk("tog_done", {63'h0, done}, 64'h1);
        chk("tog_pass", {63'h0, pass}, 64'h1);
        chk("tog_cnt_final", {48'h0, count}, 64'd4);
        chk("tog_sig_final", {32'h0, signature}, {32'h0, g});
        offer(1'b1, rnd_vec(), "tog_after");

        // start mid-run is ignored: run still ends at the original target and golden
        for (int i = 0; i < 3; i++) vecs[i] = rnd_vec();
        g = misr(misr(misr(SEED, vecs[0]), vecs[1]), vecs[2]);
        do_start(16'd3, g);
        offer(1'b1, vecs[0], "mid");
        start = 1'b1; num_vectors = 16'd9; golden = 32'h0;
        step();
        start = 1'b0;
        chk("mid_busy", {63'h0, busy}, 64'h1);
        chk("mid_hold_cnt", {48'h0, count}, 64'd1);
        chk("mid_hold_sig", {32'h0, signature}, {32'h0, model_sig});
        offer(1'b1, vecs[1], "mid");
        offer(1'b1, vecs[2], "mid");
        chk("mid_done", {63'h0, done}, 64'h1);
        chk("mid_pass", {63'h0, pass}, 64'h1);

        // Asynchronous reset mid-run
        do_start(16'd5, 32'h12345678);
        offer(1'b1, rnd_vec(), "ar");
        offer(1'b1, rnd_vec(), "ar");
        #1 rst_n = 1'b0;
        #1;
        chk("ar_busy", {63'h0, busy}, 64'h0);
        chk("ar_ready", {63'h0, in_ready}, 64'h0);
        chk("ar_done", {63'h0, done}, 64'h0);
        chk("ar_sig", {32'h0, signature}, {32'h0, SEED});
        chk("ar_cnt", {48'h0, count}, 64'h0);
        step();
        rst_n = 1'b1;
        step();
        chk("ar_idle_busy", {63'h0, busy}, 64'h0);

        // Back-to-back runs
        for (int i = 0; i < 4; i++) vecs[i] = rnd_vec();
        g = misr(misr(SEED, vecs[0]), vecs[1]);
        do_start(16'd2, g);
        offer(1'b1, vecs[0], "b2b1");
        offer(1'b1, vecs[1], "b2b1");
        chk("b2b1_pass", {63'h0, pass}, 64'h1);
        g = misr(misr(SEED, vecs[2]), vecs[3]);
        do_start(16'd2, g);
        chk("b2b_done_drop", {63'h0, done}, 64'h0);
        chk("b2b_busy", {63'h0, busy}, 64'h1);
        chk("b2b_cnt0", {48'h0, count}, 64'h0);
        offer(1'b1, vecs[2], "b2b2");
        offer(1'b1, vecs[3], "b2b2");
        chk("b2b2_done", {63'h0, done}, 64'h1);
        chk("b2b2_pass", {63'h0, pass}, 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
